asi_ts_sync_rx: RTL and testbench

Receive-side transport-stream packet aligner for the ASI input path, in the 27 MHz domain. Takes the decoded byte stream from the ASI deserialiser, hunts for the 0x47 sync byte and auto-detects 188- or 204-byte packets. After lock, it forwards aligned bytes with packet-start, byte-index and packet-length flags. Downstream it feeds the same packet-oriented byte bus (data/valid/sync) the output path consumes.

---
 rtl/asi_ts_sync_rx_pkg.sv | 22 ++
 rtl/asi_ts_sync_rx_if.sv | 25 ++
 rtl/asi_ts_sync_rx.sv | 194 +++++++++++++++++++
 tb/tb_asi_ts_sync_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asi_ts_sync_rx_pkg.sv
// Shared transport-stream constants and state encoding.
// The ASI output packetiser uses the same definitions.
package asi_ts_sync_rx_pkg;

  typedef logic [7:0] ts_byte_t;

  localparam ts_byte_t TS_SYNC_BYTE = 8'h47;
  localparam ts_byte_t TS_LEN_188   = 8'd188;
  localparam ts_byte_t TS_LEN_204   = 8'd204;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

  // Packet length selected by the 188/204 flag.
  function automatic ts_byte_t ts_len(input logic is188);
    return is188 ? TS_LEN_188 : TS_LEN_204;
  endfunction

endpackage

// File: rtl/asi_ts_sync_rx_if.sv
// Byte bus of the TS aligner: raw bytes in, aligned packet bytes and status out.
// master = upstream/consumer side, slave = the aligner.
interface asi_ts_sync_rx_if;
  import asi_ts_sync_rx_pkg::*;

  ts_byte_t i_Data;
  logic     i_Valid;
  ts_byte_t o_Data;
  logic     o_Valid;
  logic     o_Sync;
  ts_byte_t o_ContaByte;
  logic     o_BtsComp;
  logic     o_Lock;
  logic     o_ErrSync;

  modport master (
    output i_Data, i_Valid,
    input  o_Data, o_Valid, o_Sync, o_ContaByte, o_BtsComp, o_Lock, o_ErrSync
  );

  modport slave (
    input  i_Data, i_Valid,
    output o_Data, o_Valid, o_Sync, o_ContaByte, o_BtsComp, o_Lock, o_ErrSync
  );
endinterface

// File: rtl/asi_ts_sync_rx.sv
// ASI receive TS aligner: hunts 0x47, auto-detects 188/204-byte packets and
// forwards aligned bytes with sync, byte index and length flags once locked.
module asi_ts_sync_rx
  import asi_ts_sync_rx_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 3
) (
  input  logic               i_Clk27Mhz,
  input  logic               i_nRst27Mhz,
  asi_ts_sync_rx_if.slave    io_Bus
);

  localparam logic [2:0] LC = 3'(LOCK_COUNT);
  localparam logic [2:0] UC = 3'(UNLOCK_COUNT);

  ts_state_e r_State;
  ts_byte_t  r_Pos;
  logic [2:0] r_Good;
  logic [2:0] r_Miss;
  logic      r_LenKnown;
  logic      r_Len188;
  logic      r_BtsComp;
  ts_byte_t  r_Data;
  logic      r_Valid;
  logic      r_Sync;
  ts_byte_t  r_ContaByte;
  logic      r_ErrSync;

  ts_state_e w_State_n;
  ts_byte_t  w_Pos_n;
  logic [2:0] w_Good_n;
  logic [2:0] w_Miss_n;
  logic      w_LenKnown_n;
  logic      w_Len188_n;
  logic      w_OutValid;
  logic      w_OutSync;
  logic      w_OutErr;
  ts_byte_t  w_OutConta;
  logic      w_BtsLoad;
  logic      w_IsSync;
  logic      w_SyncOk;
  ts_byte_t  w_PosInc;
  ts_byte_t  w_PosWrap;
  ts_byte_t  w_LenVal;
  logic [2:0] w_GoodNext;
  logic [2:0] w_MissInc;

  always_comb begin
    w_State_n    = r_State;
    w_Pos_n      = r_Pos;
    w_Good_n     = r_Good;
    w_Miss_n     = r_Miss;
    w_LenKnown_n = r_LenKnown;
    w_Len188_n   = r_Len188;
    w_OutValid   = 1'b0;
    w_OutSync    = 1'b0;
    w_OutErr     = 1'b0;
    w_OutConta   = r_ContaByte;
    w_BtsLoad    = 1'b0;
    w_SyncOk     = 1'b0;
    w_IsSync     = (io_Bus.i_Data == TS_SYNC_BYTE);
    w_PosInc     = r_Pos + 8'd1;
    w_LenVal     = ts_len(r_Len188);
    w_PosWrap    = (r_Pos == w_LenVal - 8'd1) ? '0 : w_PosInc;
    w_GoodNext   = r_LenKnown ? (r_Good + 3'd1) : 3'd2;
    w_MissInc    = r_Miss + 3'd1;

    if (io_Bus.i_Valid) begin
      unique case (r_State)
        HUNT: begin
          if (w_IsSync) begin
            w_State_n    = VERIFY;
            w_Pos_n      = '0;
            w_Good_n     = 3'd1;
            w_LenKnown_n = 1'b0;
          end
        end

        VERIFY: begin
          w_Pos_n = w_PosInc;
          if (!r_LenKnown) begin
            // 188 is checked before 204; the first spacing that holds a sync wins
            if (w_IsSync && (w_PosInc == TS_LEN_188 || w_PosInc == TS_LEN_204)) begin
              w_SyncOk     = 1'b1;
              w_LenKnown_n = 1'b1;
              w_Len188_n   = (w_PosInc == TS_LEN_188);
            end else if (w_PosInc == TS_LEN_204) begin
              w_State_n = HUNT;
            end
          end else if (w_PosInc == w_LenVal) begin
            if (w_IsSync) w_SyncOk  = 1'b1;
            else          w_State_n = HUNT;
          end

          if (w_SyncOk) begin
            w_Pos_n  = '0;
            w_Good_n = w_GoodNext;
            if (w_GoodNext == LC) begin
              w_State_n  = LOCK;
              w_Miss_n   = '0;
              w_BtsLoad  = 1'b1;
              w_OutValid = 1'b1;
              w_OutSync  = 1'b1;
              w_OutConta = '0;
            end
          end

          if (w_State_n == HUNT) begin
            w_Pos_n  = '0;
            w_Good_n = '0;
          end
        end

        LOCK: begin
          w_Pos_n = w_PosWrap;
          if (w_PosWrap == '0) begin
            if (w_IsSync) begin
              w_Miss_n   = '0;
              w_OutValid = 1'b1;
              w_OutSync  = 1'b1;
              w_OutConta = '0;
            end else begin
              w_OutErr = 1'b1;
              w_Miss_n = w_MissInc;
              // Final miss drops lock; that byte is not forwarded
              if (w_MissInc == UC) begin
                w_State_n = HUNT;
                w_Pos_n   = '0;
                w_Good_n  = '0;
                w_Miss_n  = '0;
              end else begin
                w_OutValid = 1'b1;
                w_OutSync  = 1'b1;
                w_OutConta = '0;
              end
            end
          end else begin
            w_OutValid = 1'b1;
            w_OutConta = w_PosWrap;
          end
        end

        default: begin
          w_State_n = HUNT;
          w_Pos_n   = '0;
          w_Good_n  = '0;
          w_Miss_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk27Mhz or negedge i_nRst27Mhz) begin
    if (!i_nRst27Mhz) begin
      r_State     <= HUNT;
      r_Pos       <= '0;
      r_Good      <= '0;
      r_Miss      <= '0;
      r_LenKnown  <= 1'b0;
      r_Len188    <= 1'b1;
      r_BtsComp   <= 1'b1;
      r_Data      <= '0;
      r_Valid     <= 1'b0;
      r_Sync      <= 1'b0;
      r_ContaByte <= '0;
      r_ErrSync   <= 1'b0;
    end else begin
      r_State    <= w_State_n;
      r_Pos      <= w_Pos_n;
      r_Good     <= w_Good_n;
      r_Miss     <= w_Miss_n;
      r_LenKnown <= w_LenKnown_n;
      r_Len188   <= w_Len188_n;
      r_Valid    <= w_OutValid;
      r_Sync     <= w_OutSync;
      r_ErrSync  <= w_OutErr;
      if (w_OutValid) begin
        r_Data      <= io_Bus.i_Data;
        r_ContaByte <= w_OutConta;
      end
      if (w_BtsLoad) r_BtsComp <= w_Len188_n;
    end
  end

  assign io_Bus.o_Data      = r_Data;
  assign io_Bus.o_Valid     = r_Valid;
  assign io_Bus.o_Sync      = r_Sync;
  assign io_Bus.o_ContaByte = r_ContaByte;
  assign io_Bus.o_BtsComp   = r_BtsComp;
  assign io_Bus.o_Lock      = (r_State == LOCK);
  assign io_Bus.o_ErrSync   = r_ErrSync;

endmodule

// File: tb/tb_asi_ts_sync_rx.sv
// Scoreboard bench for asi_ts_sync_rx: random TS streams against a packet-level model.
module tb_asi_ts_sync_rx;
  import asi_ts_sync_rx_pkg::*;

  localparam int LC = 3;
  localparam int UC = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #18 clk = ~clk;

  asi_ts_sync_rx_if bus ();

  asi_ts_sync_rx #(.LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut (
    .i_Clk27Mhz (clk),
    .i_nRst27Mhz(rst_n),
    .io_Bus     (bus.slave)
  );

  typedef struct packed {
    bit       v;
    bit [7:0] d;
    bit       s;
    bit [7:0] c;
    bit       b;
    bit       e;
    bit       l;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;
  int lock_rises = 0;
  bit prev_lock  = 0;

  // Reference model: position counted from the last accepted sync in plain ints
  int m_mode;  // 0 hunting, 1 verifying, 2 locked
  int m_pos, m_good, m_miss, m_len;
  bit m_bts;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_len = 0; m_bts = 1;
  endtask

  task automatic push(input bit v, input bit [7:0] d, input bit s, input int c,
                      input bit e, input bit l);
    exp_t x;
    x.v = v; x.d = d; x.s = s; x.c = 8'(c); x.b = m_bts; x.e = e; x.l = l;
    q.push_back(x);
  endtask

  task automatic model_byte(input bit [7:0] d);
    bit is_sync;
    is_sync = (d == 8'h47);
    case (m_mode)
      0: if (is_sync) begin m_mode = 1; m_pos = 0; m_good = 1; m_len = 0; end
      1: begin
        m_pos = m_pos + 1;
        if (m_len == 0) begin
          if (is_sync && (m_pos == 188 || m_pos == 204)) begin
            m_len = m_pos; m_pos = 0; m_good = 2;
          end else if (m_pos >= 204) m_mode = 0;
        end else if (m_pos == m_len) begin
          if (is_sync) begin m_pos = 0; m_good = m_good + 1; end
          else m_mode = 0;
        end
        if (m_mode == 1 && m_pos == 0 && m_good == LC) begin
          m_mode = 2; m_miss = 0; m_bts = (m_len == 188);
          push(1, d, 1, 0, 0, 1);
        end
      end
      default: begin
        m_pos = (m_pos + 1) % m_len;
        if (m_pos != 0) push(1, d, 0, m_pos, 0, 1);
        else if (is_sync) begin m_miss = 0; push(1, d, 1, 0, 0, 1); end
        else begin
          m_miss = m_miss + 1;
          if (m_miss == UC) begin m_mode = 0; push(0, d, 0, 0, 1, 0); end
          else push(1, d, 1, 0, 1, 1);
        end
      end
    endcase
  endtask

  task automatic drive(input bit [7:0] d, input int gap);
    repeat (gap) begin @(posedge clk); #1; bus.i_Valid = 1'b0; end
    @(posedge clk); #1;
    bus.i_Data = d; bus.i_Valid = 1'b1;
    model_byte(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; bus.i_Valid = 1'b0; end
  endtask

  function automatic bit [7:0] payload();
    bit [7:0] d;
    d = 8'($urandom);
    if (d == 8'h47) d = 8'h46;
    return d;
  endfunction

  // gapmode: 0 none, -1 fixed 1-of-7, >0 random 0..gapmode idles
  task automatic send_pkt(input int len, input bit [7:0] sync, input int stray, input int gapmode);
    bit [7:0] d;
    int g;
    for (int i = 0; i < len; i++) begin
      d = (i == 0) ? sync : ((i == stray) ? 8'h47 : payload());
      g = (gapmode < 0) ? 6 : ((gapmode > 0) ? int'($urandom_range(gapmode, 0)) : 0);
      drive(d, g);
    end
  endtask

  task automatic do_reset();
    bus.i_Valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_lock = 0;
    else begin
      if (bus.o_Lock && !prev_lock) lock_rises++;
      prev_lock = bus.o_Lock;
      if (bus.o_ErrSync) err_pulses++;
      if (bus.o_Valid) check("valid_implies_lock", int'(bus.o_Lock), 1);
      if (bus.o_Sync) check("sync_conta_zero", int'(bus.o_ContaByte), 0);
      if (bus.o_Valid || bus.o_ErrSync) begin
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          check("o_Valid", int'(bus.o_Valid), int'(e.v));
          check("o_ErrSync", int'(bus.o_ErrSync), int'(e.e));
          check("o_Lock", int'(bus.o_Lock), int'(e.l));
          check("o_BtsComp", int'(bus.o_BtsComp), int'(e.b));
          if (e.v) begin
            check("o_Data", int'(bus.o_Data), int'(e.d));
            check("o_Sync", int'(bus.o_Sync), int'(e.s));
            check("o_ContaByte", int'(bus.o_ContaByte), int'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #(36 * 60000);
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base_lock, base_err;
    bus.i_Data = '0; bus.i_Valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_Data", int'(bus.o_Data), 0);
    check("rst_o_Valid", int'(bus.o_Valid), 0);
    check("rst_o_Sync", int'(bus.o_Sync), 0);
    check("rst_o_ContaByte", int'(bus.o_ContaByte), 0);
    check("rst_o_BtsComp", int'(bus.o_BtsComp), 1);
    check("rst_o_Lock", int'(bus.o_Lock), 0);
    check("rst_o_ErrSync", int'(bus.o_ErrSync), 0);
    rst_n = 1'b1;

    // 188 mode
    base_lock = lock_rises;
    repeat (5) send_pkt(188, 8'h47, -1, 0);
    idle(3);
    check("s188_lock_rises", lock_rises - base_lock, 1);
    check("s188_lock", int'(bus.o_Lock), 1);
    check("s188_bts", int'(bus.o_BtsComp), 1);

    // 204 with stray 0x47 at offset 188 of the first packet
    do_reset();
    base_lock = lock_rises;
    send_pkt(204, 8'h47, 188, 0);
    repeat (5) send_pkt(204, 8'h47, -1, 0);
    idle(3);
    check("s204_lock_rises", lock_rises - base_lock, 1);
    check("s204_bts", int'(bus.o_BtsComp), 0);

    // Gapped 188 stream
    do_reset();
    repeat (3) send_pkt(188, 8'h47, -1, 0);
    repeat (2) send_pkt(188, 8'h47, -1, -1);
    send_pkt(188, 8'h47, -1, 3);
    idle(3);
    check("gap_lock", int'(bus.o_Lock), 1);

    // Sync loss: two corruptions hold lock, good sync clears, three drop it
    base_err = err_pulses;
    send_pkt(188, 8'h00, -1, 0);
    send_pkt(188, 8'hB8, -1, 0);
    send_pkt(188, 8'h47, -1, 0);
    idle(2);
    check("loss2_errs", err_pulses - base_err, 2);
    check("loss2_lock", int'(bus.o_Lock), 1);
    base_err = err_pulses;
    base_lock = lock_rises;
    send_pkt(188, 8'h00, -1, 0);
    send_pkt(188, 8'h01, -1, 0);
    send_pkt(188, 8'h02, -1, 0);
    idle(2);
    check("loss3_errs", err_pulses - base_err, 3);
    check("loss3_lock", int'(bus.o_Lock), 0);
    repeat (4) send_pkt(188, 8'h47, -1, 2);
    idle(3);
    check("loss_relock", lock_rises - base_lock, 1);

    // Length switch 188 -> 204
    base_err = err_pulses;
    base_lock = lock_rises;
    repeat (6) send_pkt(204, 8'h47, -1, 0);
    idle(3);
    check("switch_errs", err_pulses - base_err, 3);
    check("switch_relock", lock_rises - base_lock, 1);
    check("switch_bts", int'(bus.o_BtsComp), 0);

    // Reset mid-packet at o_ContaByte = 100
    drive(8'h47, 0);
    for (int i = 1; i <= 100; i++) drive(payload(), 0);
    idle(1);
    @(negedge clk); #2;
    check("pre_rst_conta", int'(bus.o_ContaByte), 100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_Valid", int'(bus.o_Valid), 0);
    check("mid_rst_o_Data", int'(bus.o_Data), 0);
    check("mid_rst_o_ContaByte", int'(bus.o_ContaByte), 0);
    check("mid_rst_o_Lock", int'(bus.o_Lock), 0);
    check("mid_rst_o_BtsComp", int'(bus.o_BtsComp), 1);
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base_lock = lock_rises;
    for (int i = 101; i < 204; i++) drive(payload(), 0);
    repeat (4) send_pkt(204, 8'h47, -1, 0);
    idle(3);
    check("rst_relock", lock_rises - base_lock, 1);
    check("rst_relock_bts", int'(bus.o_BtsComp), 0);

    idle(3);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
